// File: rtl/oled_spi_monitor_if.sv
// Bus bundle for the OLED SPI monitor: the sniffed OLED lines, the captured-byte
// stream with its valid/ready handshake, the overflow flag and the byte counters.
// master = the side that drives the OLED lines and consumes bytes; slave = the monitor.
interface oled_spi_monitor_if;
  logic        oled_sclk;
  logic        oled_sdin;
  logic        oled_dc;
  logic        oled_res;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        byte_valid;
  logic        byte_ready;
  logic        overflow;
  logic        clear_overflow;
  logic [15:0] cmd_count;
  logic [15:0] data_count;

  modport master (
    output oled_sclk, oled_sdin, oled_dc, oled_res, byte_ready, clear_overflow,
    input  byte_data, byte_dc, byte_valid, overflow, cmd_count, data_count
  );

  modport slave (
    input  oled_sclk, oled_sdin, oled_dc, oled_res, byte_ready, clear_overflow,
    output byte_data, byte_dc, byte_valid, overflow, cmd_count, data_count
  );
endinterface

// File: rtl/oled_spi_monitor.sv
// Passive monitor of an OLED SPI link. Synchronizes the OLED lines, assembles
// MSB-first bytes on SCLK rising edges, tags each with its DC level and queues
// {dc, byte} in a first-word-fall-through FIFO with registered head outputs.
// Partial bytes are discarded on an inter-bit timeout or while the OLED is held
// in reset. Overflow is sticky; command/data byte counters saturate.
module oled_spi_monitor #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 4096
) (
  input logic              clk,
  input logic              reset,
  oled_spi_monitor_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [0:0]    ST_IDLE    = 1'b0;
  localparam logic [0:0]    ST_SHIFT   = 1'b1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(FIFO_DEPTH);

  // synchronizer stages, bit order {res, dc, sdin, sclk}
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic       sclk_prev_r;
  logic       sclk_s;
  logic       sdin_s;
  logic       dc_s;
  logic       res_s;
  logic       sclk_edge_s;

  // capture state
  logic [0:0]    state_r;
  logic [2:0]    bit_cnt_r;
  logic [6:0]    shift_r;
  logic [TW-1:0] timer_r;
  logic          push_s;
  logic [8:0]    push_word_s;

  // FIFO state
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s;
  logic          pop_s;
  logic          push_ok_s;
  logic          drop_s;
  logic [AW:0]   count_next_s;
  logic [AW-1:0] rd_next_s;
  logic [8:0]    head_next_s;

  // registered outputs
  logic [7:0]  byte_data_r;
  logic        byte_dc_r;
  logic        byte_valid_r;
  logic        overflow_r;
  logic [15:0] cmd_count_r;
  logic [15:0] data_count_r;

  assign sclk_s = sync2_r[0];
  assign sdin_s = sync2_r[1];
  assign dc_s   = sync2_r[2];
  assign res_s  = sync2_r[3];

  // two-flop synchronizers plus previous SCLK sample; everything idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r     <= 4'hF;
      sync2_r     <= 4'hF;
      sclk_prev_r <= 1'b1;
    end else begin
      sync1_r     <= {bus.oled_res, bus.oled_dc, bus.oled_sdin, bus.oled_sclk};
      sync2_r     <= sync1_r;
      sclk_prev_r <= sclk_s;
    end
  end

  // edge detect and byte-complete push; bit counter of 7 means this edge carries bit 8
  always_comb begin
    sclk_edge_s = sclk_s & ~sclk_prev_r;
    push_s      = res_s & sclk_edge_s & (bit_cnt_r == 3'd7);
    push_word_s = {dc_s, shift_r, sdin_s};
  end

  // capture FSM: shift on edges, abandon partial bytes on timeout or OLED reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
      timer_r   <= '0;
    end else if (!res_s) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      timer_r   <= '0;
    end else if (sclk_edge_s) begin
      shift_r <= {shift_r[5:0], sdin_s};
      timer_r <= '0;
      if (bit_cnt_r == 3'd7) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 3'd0;
      end else begin
        state_r   <= ST_SHIFT;
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
    end else begin
      case (state_r)
        ST_SHIFT: begin
          if (timer_r == TIMER_LAST) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            timer_r   <= '0;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= 3'd0;
          timer_r   <= '0;
        end
      endcase
    end
  end

  // FIFO next-state: a full FIFO still accepts a push when a pop frees a slot the same cycle
  always_comb begin
    full_s    = (count_r == CNT_FULL);
    pop_s     = byte_valid_r & bus.byte_ready;
    push_ok_s = push_s & (~full_s | pop_s);
    drop_s    = push_s & ~push_ok_s;
    rd_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + (AW + 1)'(1);
      2'b01:   count_next_s = count_r - (AW + 1)'(1);
      default: count_next_s = count_r;
    endcase
    // the incoming word becomes the head only if nothing else remains after this pop
    if (count_next_s == '0) begin
      head_next_s = {byte_dc_r, byte_data_r};
    end else if (push_ok_s && (count_r == (AW + 1)'(pop_s))) begin
      head_next_s = push_word_s;
    end else begin
      head_next_s = mem[rd_next_s];
    end
  end

  // FIFO storage; no reset needed, occupancy is tracked by count_r
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem[wr_ptr_r] <= push_word_s;
    end
  end

  // FIFO pointers, occupancy and registered head-of-FIFO outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      byte_dc_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r     <= rd_next_s;
      count_r      <= count_next_s;
      byte_valid_r <= (count_next_s != '0);
      byte_dc_r    <= head_next_s[8];
      byte_data_r  <= head_next_s[7:0];
    end
  end

  // sticky overflow; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  // saturating counters of accepted command and data bytes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_count_r  <= 16'h0000;
      data_count_r <= 16'h0000;
    end else if (push_ok_s) begin
      if (push_word_s[8]) begin
        if (data_count_r != 16'hFFFF) begin
          data_count_r <= data_count_r + 16'h0001;
        end
      end else begin
        if (cmd_count_r != 16'hFFFF) begin
          cmd_count_r <= cmd_count_r + 16'h0001;
        end
      end
    end
  end

  assign bus.byte_data  = byte_data_r;
  assign bus.byte_dc    = byte_dc_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.overflow   = overflow_r;
  assign bus.cmd_count  = cmd_count_r;
  assign bus.data_count = data_count_r;

endmodule

// File: tb/tb_oled_spi_monitor.sv
// Directed bench for oled_spi_monitor: drives SPI bytes with an SCLK period of
// 8 clk, logs every pop into a queue and compares against hand-built expectations.
module tb_oled_spi_monitor;

  localparam int TIMEOUT = 4096;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];

  oled_spi_monitor_if bus();

  oled_spi_monitor #(.FIFO_DEPTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every accepted pop as {dc, byte}
  always @(posedge clk) begin
    if (!reset && bus.byte_valid && bus.byte_ready) begin
      rx_q.push_back({bus.byte_dc, bus.byte_data});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.oled_sclk = 1'b0;
      bus.oled_sdin = b[7-i];
      tick(4);
      bus.oled_sclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    bus.oled_dc = dc;
    tick(2);
    send_bits(b, 8);
    tick(2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.byte_ready = 1'b1;
    tick(1);
    while (bus.byte_valid && n < 100) begin
      tick(1);
      n++;
    end
    check("drain_empty", {31'd0, bus.byte_valid}, 32'd0);
  endtask

  task automatic compare_rx(input string tag);
    logic [31:0] obs;
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < rx_q.size()) ? {23'd0, rx_q[i]} : 32'hDEAD;
      check({tag, "_byte"}, obs, {23'd0, exp_q[i]});
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.oled_sclk = 1'b1;
    bus.oled_sdin = 1'b0;
    bus.oled_dc = 1'b0;
    bus.oled_res = 1'b1;
    bus.byte_ready = 1'b0;
    bus.clear_overflow = 1'b0;
    tick(3);

    // reset state
    check("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("rst_data", {24'd0, bus.byte_data}, 32'h00);
    check("rst_dc", {31'd0, bus.byte_dc}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check("rst_cmd", {16'd0, bus.cmd_count}, 32'd0);
    check("rst_data_cnt", {16'd0, bus.data_count}, 32'd0);
    reset = 1'b0;
    tick(3);

    // single command byte with consumer always ready
    bus.byte_ready = 1'b1;
    send_byte(8'hAF, 1'b0);
    tick(4);
    exp_q.push_back(9'h0AF);
    compare_rx("cmd_af");
    check("af_cmd_cnt", {16'd0, bus.cmd_count}, 32'd1);
    check("af_data_cnt", {16'd0, bus.data_count}, 32'd0);

    // fill FIFO with 17 data bytes; the last is dropped
    bus.byte_ready = 1'b0;
    tick(2);
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b1);
    end
    tick(4);
    check("ovf_set", {31'd0, bus.overflow}, 32'd1);
    check("ovf_data_cnt", {16'd0, bus.data_count}, 32'd16);
    check("ovf_cmd_cnt", {16'd0, bus.cmd_count}, 32'd1);
    check("full_head", {23'd0, bus.byte_dc, bus.byte_data}, 32'h100);
    bus.clear_overflow = 1'b1;
    tick(1);
    bus.clear_overflow = 1'b0;
    tick(1);
    check("ovf_clear", {31'd0, bus.overflow}, 32'd0);

    // full FIFO: last bit edge of 0x5A coincides with a pop
    bus.oled_dc = 1'b1;
    tick(2);
    send_bits(8'h5A, 7);
    bus.oled_sclk = 1'b0;
    bus.oled_sdin = 1'b0;
    tick(4);
    bus.oled_sclk = 1'b1;
    tick(2);
    bus.byte_ready = 1'b1;
    tick(1);
    bus.byte_ready = 1'b0;
    tick(4);
    check("sim_ovf", {31'd0, bus.overflow}, 32'd0);
    check("sim_data_cnt", {16'd0, bus.data_count}, 32'd17);
    check("sim_head", {23'd0, bus.byte_dc, bus.byte_data}, 32'h101);
    drain();
    exp_q.push_back(9'h100);
    for (int i = 1; i < 16; i++) begin
      exp_q.push_back({1'b1, 8'(i)});
    end
    exp_q.push_back(9'h15A);
    compare_rx("full_fifo");

    // partial byte times out; pops on an empty FIFO do nothing
    bus.oled_dc = 1'b0;
    tick(2);
    send_bits(8'h3C, 5);
    tick(TIMEOUT + 10);
    check("empty_pop_valid", {31'd0, bus.byte_valid}, 32'd0);
    send_byte(8'hA5, 1'b0);
    tick(4);
    exp_q.push_back(9'h0A5);
    compare_rx("timeout");
    check("to_cmd_cnt", {16'd0, bus.cmd_count}, 32'd2);

    // OLED reset mid-byte discards partial bits, keeps FIFO contents
    bus.byte_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    bus.oled_dc = 1'b0;
    send_bits(8'hE0, 3);
    bus.oled_res = 1'b0;
    tick(10);
    bus.oled_res = 1'b1;
    tick(5);
    send_byte(8'h8D, 1'b0);
    tick(4);
    check("res_head", {23'd0, bus.byte_dc, bus.byte_data}, 32'h111);
    check("res_cmd_cnt", {16'd0, bus.cmd_count}, 32'd3);
    check("res_data_cnt", {16'd0, bus.data_count}, 32'd18);
    drain();
    exp_q.push_back(9'h111);
    exp_q.push_back(9'h08D);
    compare_rx("oled_res");

    // system reset with queued bytes and a partial byte in flight
    bus.byte_ready = 1'b0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_bits(8'hF0, 4);
    reset = 1'b1;
    tick(2);
    check("mid_rst_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("mid_rst_cmd", {16'd0, bus.cmd_count}, 32'd0);
    check("mid_rst_data_cnt", {16'd0, bus.data_count}, 32'd0);
    check("mid_rst_ovf", {31'd0, bus.overflow}, 32'd0);
    reset = 1'b0;
    tick(2);
    send_byte(8'h12, 1'b1);
    tick(4);
    check("post_rst_head", {23'd0, bus.byte_dc, bus.byte_data}, 32'h112);
    check("post_rst_valid", {31'd0, bus.byte_valid}, 32'd1);
    check("post_rst_data_cnt", {16'd0, bus.data_count}, 32'd1);
    check("post_rst_cmd", {16'd0, bus.cmd_count}, 32'd0);
    drain();
    exp_q.push_back(9'h112);
    compare_rx("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_spi_monitor.md
OLED_SPI_MONITOR -- requirements
Module: oled_spi_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, captured-byte FIFO depth (power of 2, 4..64).
REQ-002 SHALL have parameter TIMEOUT, default 4096, clk cycles without an SCLK rising edge before a partial byte is discarded.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port oled_sclk  input  1  OLED serial clock, asynchronous to clk, idle high.
REQ-006 SHALL have port oled_sdin  input  1  OLED serial data, MSB first.
REQ-007 SHALL have port oled_dc  input  1  OLED data/command select; 1 = display data, 0 = command.
REQ-008 SHALL have port oled_res  input  1  OLED reset, active-low.
REQ-009 SHALL have port byte_data  output  8  head-of-FIFO byte.
REQ-010 SHALL have port byte_dc  output  1  DC value captured with byte_data.
REQ-011 SHALL have port byte_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port byte_ready  input  1  consumer pop; pop occurs when byte_valid and byte_ready are both high.
REQ-013 SHALL have port overflow  output  1  sticky flag: a completed byte was dropped.
REQ-014 SHALL have port clear_overflow  input  1  single-cycle clear of overflow.
REQ-015 SHALL have port cmd_count  output  16  saturating count of command bytes accepted into the FIFO.
REQ-016 SHALL have port data_count  output  16  saturating count of data bytes accepted into the FIFO.

Function
REQ-017 SHALL pass oled_sclk, oled_sdin, oled_dc and oled_res through 2-flop synchronizers each before any use.
REQ-018 SHALL detect an SCLK rising edge as synced sclk = 1 while its previous-cycle value = 0 (one pulse per edge).
REQ-019 SHALL implement a capture FSM with states IDLE (0 bits held) and SHIFT (1..7 bits held), using a 3-bit bit counter.
REQ-020 SHALL, on each edge, shift synced sdin into the LSB of the shift register and increment the bit counter.
REQ-021 SHALL, on the edge carrying bit 8, form the byte and latch synced dc, push {dc, byte} in that same cycle, and return to IDLE.
REQ-022 SHALL make the pushed byte visible on byte_valid/byte_data the cycle after the push when the FIFO was empty (first-word fall-through).
REQ-023 SHALL, when the FIFO is full at push time without a simultaneous pop, drop the byte, set overflow, and leave both counters unchanged.
REQ-024 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle; overflow SHALL NOT be set.
REQ-025 SHALL, when a push and clear_overflow coincide with a drop, leave overflow set (set wins).
REQ-026 SHALL increment cmd_count (dc=0) or data_count (dc=1) only for accepted pushes; each counter SHALL saturate at 0xFFFF.
REQ-027 SHALL count TIMEOUT cycles without an edge while in SHIFT, then discard the partial bits and enter IDLE; the timer SHALL be held at 0 while in IDLE.
REQ-028 SHALL, while synced oled_res = 0, hold the FSM in IDLE, discard partial bits and ignore edges; FIFO contents and counters SHALL be retained.
REQ-029 SHALL keep byte_data/byte_dc stable while byte_valid is high and byte_ready is low.
REQ-030 SHALL have a pop on an empty FIFO produce no effect.

Reset
REQ-031 SHALL, on reset assertion, immediately put the FSM in IDLE, empty the FIFO and drive byte_valid=0, byte_data=0x00, byte_dc=0, overflow=0, cmd_count=0, data_count=0, and synchronizer flops to 1 (sclk idle high).
REQ-032 SHALL discard a partial byte or FIFO contents present when reset is asserted mid-transfer; capture SHALL resume at the first edge after reset release.

Verification
REQ-033 SHALL cover: dc=0, send 0xAF (SCLK period 8 clk), byte_ready=1 -> one pop of byte_data=0xAF, byte_dc=0; cmd_count=1, data_count=0.
REQ-034 SHALL cover: byte_ready=0, send 17 data bytes 0x00..0x10 -> bytes 0x00..0x0F are held, 0x10 is dropped, overflow=1, data_count=16; then clear_overflow -> overflow=0.
REQ-035 SHALL cover: send 5 bits of 0x3C, then idle TIMEOUT+10 cycles, then send 0xA5 -> only 0xA5 is received.
REQ-036 SHALL cover: drive oled_res low after 3 bits, then release and send 0x8D -> only 0x8D is received; prior FIFO contents are intact.
REQ-037 SHALL cover: FIFO full, byte_ready=1, 8th bit edge in the same cycle as a pop -> push accepted, overflow=0, FIFO stays full.
REQ-038 SHALL cover: assert reset with 3 bytes queued and 4 bits of a 4th byte shifted -> byte_valid=0, counters 0; the next full byte 0x12 is received alone.
